lim_debounce_irq: RTL and testbench



---
 rtl/lim_debounce_pkg.sv | 33 +++
 rtl/lim_deb_chan.sv | 54 +++++
 rtl/lim_debounce_irq.sv | 139 +++++++++++++
 tb/tb_lim_debounce_irq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lim_debounce_pkg.sv
// Shared constants for the limit-switch debounce/interrupt block: register
// offsets, the CFG enable bit position and the default counter width.
package lim_debounce_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int CFG_EN_BIT = 31;

    localparam logic [4:0] LIMD_STATE    = 5'h00;
    localparam logic [4:0] LIMD_RAW      = 5'h04;
    localparam logic [4:0] LIMD_EVENT    = 5'h08;
    localparam logic [4:0] LIMD_RISE_EN  = 5'h0C;
    localparam logic [4:0] LIMD_FALL_EN  = 5'h10;
    localparam logic [4:0] LIMD_IRQ_MASK = 5'h14;
    localparam logic [4:0] LIMD_CFG      = 5'h18;
    localparam logic [4:0] LIMD_EVTCNT   = 5'h1C;

    // Word index of each register: byte offset bits [4:2].
    typedef enum logic [2:0] {
        REG_STATE    = 3'd0,
        REG_RAW      = 3'd1,
        REG_EVENT    = 3'd2,
        REG_RISE_EN  = 3'd3,
        REG_FALL_EN  = 3'd4,
        REG_IRQ_MASK = 3'd5,
        REG_CFG      = 3'd6,
        REG_EVTCNT   = 3'd7
    } limd_reg_e;

    function automatic limd_reg_e limd_decode(input logic [4:0] addr);
        return limd_reg_e'(addr[4:2]);
    endfunction

endpackage

// File: rtl/lim_deb_chan.sv
// One debounced limit channel: counts consecutive differing samples and
// flips the stable bit once the run reaches thr_eff, pulsing rise/fall.
module lim_deb_chan
    import lim_debounce_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic             sys_clock,
    input  logic             resetn,
    input  logic             sample_bit,
    input  logic             sample_valid,
    input  logic             en,
    input  logic [CNT_W-1:0] thr_eff,
    output logic             state,
    output logic             rise,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             differs;
    logic             accept;

    // One extra bit so the compare stays correct even at cnt = all-ones.
    always_comb begin
        cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
        differs = sample_valid && en && (sample_bit != state);
        accept  = differs && (cnt_inc >= {1'b0, thr_eff});
        rise    = accept && sample_bit;
        fall    = accept && !sample_bit;
    end

    // NOTE: state uses <= only; a blocking write here would race with the
    // event logic in the parent that reads rise/fall on the same edge.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            cnt   <= '0;
            state <= INIT_LEVEL;
        end else if (!en) begin
            cnt <= '0;
        end else if (sample_valid) begin
            if (sample_bit == state) begin
                cnt <= '0;
            end else if (accept) begin
                state <= sample_bit;
                cnt   <= '0;
            end else begin
                cnt <= cnt_inc[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/lim_debounce_irq.sv
// Limit-switch debouncer with edge event latch, maskable level irq and CPU
// register port. Define LIM_DEBOUNCE_EVT_CNT_EN to add the EVT_CNT register.
module lim_debounce_irq
    import lim_debounce_pkg::*;
#(
    parameter int               CH_NUM      = 24,
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEB_DEFAULT = CNT_W'(4),
    parameter bit               INIT_LEVEL  = 1'b0
) (
    input  logic              sys_clock,
    input  logic              resetn,
    input  logic              sample_valid,
    input  logic [CH_NUM-1:0] sample_data,
    input  logic              reg_sel,
    input  logic              reg_wr,
    input  logic [4:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic [CH_NUM-1:0] lim_state,
    output logic              irq
);

    logic [CH_NUM-1:0] raw_q;
    logic [CH_NUM-1:0] event_q;
    logic [CH_NUM-1:0] rise_en_q;
    logic [CH_NUM-1:0] fall_en_q;
    logic [CH_NUM-1:0] irq_mask_q;
    logic [CNT_W-1:0]  thr_q;
    logic [CNT_W-1:0]  thr_eff;
    logic              en_q;

    logic [CH_NUM-1:0] rise_vec;
    logic [CH_NUM-1:0] fall_vec;
    logic [CH_NUM-1:0] evt_set;
    logic [CH_NUM-1:0] evt_clr;
    logic              wr_en;
    limd_reg_e         sel_reg;
    logic [31:0]       rd_word;
    logic              wdata_unused;

    assign wr_en        = reg_sel && reg_wr;
    assign sel_reg      = limd_decode(reg_addr);
    assign thr_eff      = (thr_q == '0) ? CNT_W'(1) : thr_q;
    assign wdata_unused = ^reg_wdata;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        lim_deb_chan #(
            .CNT_W      (CNT_W),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_chan (
            .sys_clock    (sys_clock),
            .resetn       (resetn),
            .sample_bit   (sample_data[i]),
            .sample_valid (sample_valid),
            .en           (en_q),
            .thr_eff      (thr_eff),
            .state        (lim_state[i]),
            .rise         (rise_vec[i]),
            .fall         (fall_vec[i])
        );
    end

    always_comb begin
        evt_set = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);
        evt_clr = (wr_en && sel_reg == REG_EVENT) ? reg_wdata[CH_NUM-1:0] : '0;
    end

    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            raw_q      <= '0;
            event_q    <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            thr_q      <= DEB_DEFAULT;
            en_q       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (sample_valid) begin
                raw_q <= sample_data;
            end
            // Set is ORed after the clear so a colliding edge is never lost.
            event_q <= (event_q & ~evt_clr) | evt_set;
            irq     <= |(event_q & irq_mask_q);
            if (wr_en) begin
                case (sel_reg)
                    REG_RISE_EN:  rise_en_q  <= reg_wdata[CH_NUM-1:0];
                    REG_FALL_EN:  fall_en_q  <= reg_wdata[CH_NUM-1:0];
                    REG_IRQ_MASK: irq_mask_q <= reg_wdata[CH_NUM-1:0];
                    REG_CFG: begin
                        thr_q <= reg_wdata[CNT_W-1:0];
                        en_q  <= reg_wdata[CFG_EN_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LIM_DEBOUNCE_EVT_CNT_EN
    logic [15:0] evt_cnt_q;

    // Counts cycles with at least one 0->1 EVENT transition, saturating.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            evt_cnt_q <= '0;
        end else if (wr_en && sel_reg == REG_EVTCNT) begin
            evt_cnt_q <= '0;
        end else if (|(evt_set & ~event_q) && evt_cnt_q != 16'hFFFF) begin
            evt_cnt_q <= evt_cnt_q + 16'd1;
        end
    end
`endif

    // NOTE: rd_word gets a default before the case so no latch is inferred
    // for offsets that do not drive it.
    always_comb begin
        rd_word = '0;
        case (sel_reg)
            REG_STATE:    rd_word[CH_NUM-1:0] = lim_state;
            REG_RAW:      rd_word[CH_NUM-1:0] = raw_q;
            REG_EVENT:    rd_word[CH_NUM-1:0] = event_q;
            REG_RISE_EN:  rd_word[CH_NUM-1:0] = rise_en_q;
            REG_FALL_EN:  rd_word[CH_NUM-1:0] = fall_en_q;
            REG_IRQ_MASK: rd_word[CH_NUM-1:0] = irq_mask_q;
            REG_CFG: begin
                rd_word[CNT_W-1:0]      = thr_q;
                rd_word[CFG_EN_BIT]     = en_q;
            end
`ifdef LIM_DEBOUNCE_EVT_CNT_EN
            REG_EVTCNT:   rd_word[15:0] = evt_cnt_q;
`endif
            default: ;
        endcase
        reg_rdata = reg_sel ? rd_word : 32'h0;
    end

endmodule

// File: tb/tb_lim_debounce_irq.sv
// Directed self-checking bench for lim_debounce_irq (default parameters).
// The EVT_CNT section follows LIM_DEBOUNCE_EVT_CNT_EN like the RTL does.
module tb_lim_debounce_irq;
    import lim_debounce_pkg::*;

    localparam int CH = 24;

    logic          sys_clock;
    logic          resetn;
    logic          sample_valid;
    logic [CH-1:0] sample_data;
    logic          reg_sel;
    logic          reg_wr;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic [CH-1:0] lim_state;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    lim_debounce_irq dut (
        .sys_clock    (sys_clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .reg_sel      (reg_sel),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .lim_state    (lim_state),
        .irq          (irq)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    typedef struct {
        logic          valid;
        logic [CH-1:0] data;
        logic [CH-1:0] exp_state;
    } smp_vec_t;

    rd_vec_t  rd_tbl[8];
    smp_vec_t smp_tbl[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        reg_sel   = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
        reg_sel = 1'b0;
        reg_wr  = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
        reg_sel  = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = a;
        #1;
        check(name, reg_rdata, exp);
        reg_sel = 1'b0;
    endtask

    task automatic sample(input logic [CH-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        reg_sel      = 1'b0;
        reg_wr       = 1'b0;
        reg_addr     = '0;
        reg_wdata    = '0;

        rd_tbl[0] = '{LIMD_STATE,    32'h0000_0000, "rst_state"};
        rd_tbl[1] = '{LIMD_RAW,      32'h0000_0000, "rst_raw"};
        rd_tbl[2] = '{LIMD_EVENT,    32'h0000_0000, "rst_event"};
        rd_tbl[3] = '{LIMD_RISE_EN,  32'h0000_0000, "rst_rise_en"};
        rd_tbl[4] = '{LIMD_FALL_EN,  32'h0000_0000, "rst_fall_en"};
        rd_tbl[5] = '{LIMD_IRQ_MASK, 32'h0000_0000, "rst_irq_mask"};
        rd_tbl[6] = '{LIMD_CFG,      32'h0000_0004, "rst_cfg"};
        rd_tbl[7] = '{LIMD_EVTCNT,   32'h0000_0000, "rst_evtcnt"};

        // thr = 4: a broken run of three, an idle gap, then a full run.
        smp_tbl[0]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[1]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[2]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[3]  = '{1'b1, 24'h000000, 24'h000000};
        smp_tbl[4]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[5]  = '{1'b0, 24'h000000, 24'h000000};
        smp_tbl[6]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[7]  = '{1'b1, 24'h000008, 24'h000000};
        smp_tbl[8]  = '{1'b1, 24'h000008, 24'h000008};
        smp_tbl[9]  = '{1'b1, 24'h000000, 24'h000008};
        smp_tbl[10] = '{1'b1, 24'h000000, 24'h000008};
        smp_tbl[11] = '{1'b1, 24'h000000, 24'h000008};
        smp_tbl[12] = '{1'b1, 24'h000000, 24'h000000};
        smp_tbl[13] = '{1'b1, 24'h000005, 24'h000000};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            check_reg(rd_tbl[i].name, rd_tbl[i].addr, rd_tbl[i].exp);
        end
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_lim_state", 32'(lim_state), 32'h0);
        reg_sel  = 1'b0;
        reg_addr = LIMD_CFG;
        #1;
        check("rdata_unselected", reg_rdata, 32'h0);

        // Debounce table
        reg_write(LIMD_CFG, 32'h8000_0004);
        for (int i = 0; i < 14; i++) begin
            sample_valid = smp_tbl[i].valid;
            sample_data  = smp_tbl[i].data;
            step();
            sample_valid = 1'b0;
            check($sformatf("deb_vec%0d", i), 32'(lim_state), 32'(smp_tbl[i].exp_state));
        end
        check_reg("raw_last", LIMD_RAW, 32'h0000_0005);
        check_reg("event_none", LIMD_EVENT, 32'h0);
        check("irq_none", 32'(irq), 32'h0);

        // Upper bits of enable registers ignore writes
        reg_write(LIMD_IRQ_MASK, 32'hFFFF_FFFF);
        check_reg("mask_width", LIMD_IRQ_MASK, 32'h00FF_FFFF);
        reg_write(LIMD_IRQ_MASK, 32'h0000_0008);
        reg_write(LIMD_RISE_EN, 32'h0000_0008);
        check_reg("rise_en_rb", LIMD_RISE_EN, 32'h0000_0008);

        // Rise on ch3 -> event, irq one cycle later, W1C clears it
        for (int i = 0; i < 3; i++) begin
            sample(24'h000008);
            check($sformatf("rise_pre%0d", i), 32'(lim_state), 32'h0);
        end
        sample(24'h000008);
        check("rise_state", 32'(lim_state), 32'h8);
        check_reg("rise_event", LIMD_EVENT, 32'h8);
        check("irq_not_yet", 32'(irq), 32'h0);
        step();
        check("irq_high", 32'(irq), 32'h1);
        reg_write(LIMD_EVENT, 32'h0000_0008);
        check_reg("event_cleared", LIMD_EVENT, 32'h0);
        step();
        check("irq_low_after_clr", 32'(irq), 32'h0);

        // Clear-versus-set collision on ch3
        for (int i = 0; i < 4; i++) sample(24'h000000);
        check("fall_state", 32'(lim_state), 32'h0);
        check_reg("fall_no_event", LIMD_EVENT, 32'h0);
        for (int i = 0; i < 3; i++) sample(24'h000008);
        reg_sel      = 1'b1;
        reg_wr       = 1'b1;
        reg_addr     = LIMD_EVENT;
        reg_wdata    = 32'h0000_0008;
        sample_valid = 1'b1;
        sample_data  = 24'h000008;
        step();
        reg_sel      = 1'b0;
        reg_wr       = 1'b0;
        sample_valid = 1'b0;
        check("collide_state", 32'(lim_state), 32'h8);
        check_reg("collide_event", LIMD_EVENT, 32'h8);
        reg_write(LIMD_EVENT, 32'h0000_0008);
        check_reg("collide_clr", LIMD_EVENT, 32'h0);

        // thr = 0 acts as 1
        reg_write(LIMD_CFG, 32'h8000_0000);
        check_reg("cfg_thr0", LIMD_CFG, 32'h8000_0000);
        sample(24'h000009);
        check("thr0_flip", 32'(lim_state), 32'h9);
        check_reg("thr0_no_event", LIMD_EVENT, 32'h0);

        // Lowering thr mid-run keeps counts; count 2 >= new thr 2
        reg_write(LIMD_CFG, 32'h8000_0004);
        sample(24'h000000);
        sample(24'h000000);
        check("thrchg_hold", 32'(lim_state), 32'h9);
        reg_write(LIMD_CFG, 32'h8000_0002);
        sample(24'h000000);
        check("thrchg_accept", 32'(lim_state), 32'h0);

        // en = 0: STATE frozen, RAW tracks, counters held at 0
        reg_write(LIMD_CFG, 32'h0000_0001);
        sample(24'hFFFFFF);
        check("dis_state0", 32'(lim_state), 32'h0);
        check_reg("dis_raw0", LIMD_RAW, 32'h00FF_FFFF);
        sample(24'hABCDEF);
        check("dis_state1", 32'(lim_state), 32'h0);
        check_reg("dis_raw1", LIMD_RAW, 32'h00AB_CDEF);
        for (int i = 0; i < 3; i++) sample(24'hFFFFFF);
        reg_write(LIMD_CFG, 32'h8000_0004);
        for (int i = 0; i < 3; i++) sample(24'hFFFFFF);
        check("reen_hold", 32'(lim_state), 32'h0);
        sample(24'hFFFFFF);
        check("reen_flip", 32'(lim_state), 32'hFF_FFFF);
        check_reg("reen_event", LIMD_EVENT, 32'h8);
        step();
        check("reen_irq", 32'(irq), 32'h1);

        // Clearing the mask drops irq
        reg_write(LIMD_IRQ_MASK, 32'h0);
        step();
        check("mask_clr_irq", 32'(irq), 32'h0);

        // Reset mid-run
        reg_write(LIMD_IRQ_MASK, 32'h8);
        sample(24'h000000);
        sample(24'h000000);
        do_reset();
        check("mid_rst_state", 32'(lim_state), 32'h0);
        check_reg("mid_rst_event", LIMD_EVENT, 32'h0);
        check_reg("mid_rst_cfg", LIMD_CFG, 32'h0000_0004);
        check_reg("mid_rst_mask", LIMD_IRQ_MASK, 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);

`ifdef LIM_DEBOUNCE_EVT_CNT_EN
        reg_write(LIMD_CFG, 32'h8000_0001);
        reg_write(LIMD_RISE_EN, 32'h3);
        reg_write(LIMD_FALL_EN, 32'h3);
        sample(24'h000001);
        reg_write(LIMD_EVENT, 32'h3);
        sample(24'h000003);
        reg_write(LIMD_EVENT, 32'h3);
        sample(24'h000000);
        check_reg("evtcnt_3", LIMD_EVTCNT, 32'h3);
        reg_write(LIMD_EVTCNT, 32'h0);
        check_reg("evtcnt_clr", LIMD_EVTCNT, 32'h0);
`else
        reg_write(LIMD_EVTCNT, 32'hFFFF_FFFF);
        check_reg("evtcnt_absent", LIMD_EVTCNT, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
